// File: rtl/mem_access_unit.sv
// mem_access_unit: single-outstanding load/store unit between the MEM stage and an SRAM-like data bus,
// with alignment checks, store lane steering, load extraction/extension and flush-with-discard.
module mem_access_unit #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [3:0]          req_op,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic                flush,
    output logic                data_req,
    output logic                data_wr,
    output logic [1:0]          data_size,
    output logic [ADDR_W-1:0]   data_addr,
    output logic [DATA_W/8-1:0] data_wstrb,
    output logic [DATA_W-1:0]   data_wdata,
    input  logic                data_addr_ok,
    input  logic                data_data_ok,
    input  logic [DATA_W-1:0]   data_rdata,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic [1:0]          rsp_exc,
    output logic [ADDR_W-1:0]   rsp_badvaddr
);
    localparam int NB = DATA_W / 8;
    localparam int OW = $clog2(NB);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    state_t              state_q, state_d;
    logic [3:0]          op_q, op_d;
    logic                discard_q, discard_d;
    logic                data_req_q, data_req_d;
    logic                data_wr_q, data_wr_d;
    logic [1:0]          data_size_q, data_size_d;
    logic [ADDR_W-1:0]   data_addr_q, data_addr_d;
    logic [NB-1:0]       data_wstrb_q, data_wstrb_d;
    logic [DATA_W-1:0]   data_wdata_q, data_wdata_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic [1:0]          rsp_exc_q, rsp_exc_d;
    logic [ADDR_W-1:0]   rsp_badvaddr_q, rsp_badvaddr_d;

    logic                legal, store, aligned;
    logic [1:0]          size;
    logic [OW-1:0]       off, rd_off;
    logic [NB-1:0]       strb;
    logic [DATA_W-1:0]   rep, sh, ext;
    logic signed [DATA_W-1:0] sx;
    int                  lsh;

    assign req_ready    = state_q == IDLE;
    assign data_req     = data_req_q;
    assign data_wr      = data_wr_q;
    assign data_size    = data_size_q;
    assign data_addr    = data_addr_q;
    assign data_wstrb   = data_wstrb_q;
    assign data_wdata   = data_wdata_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_rdata    = rsp_rdata_q;
    assign rsp_exc      = rsp_exc_q;
    assign rsp_badvaddr = rsp_badvaddr_q;

    always_comb begin
        legal   = (req_op <= 4'd7) || (DATA_W == 64 && req_op <= 4'd10);
        store   = req_op inside {4'd5, 4'd6, 4'd7, 4'd10};
        size    = (req_op inside {4'd0, 4'd1, 4'd5}) ? 2'd0 :
                  (req_op inside {4'd2, 4'd3, 4'd6}) ? 2'd1 :
                  (req_op inside {4'd9, 4'd10})     ? 2'd3 : 2'd2;
        // 3-bit mask wraps to 3'b111 for doubleword accesses
        aligned = (req_addr[2:0] & ((3'd1 << size) - 3'd1)) == 3'd0;
        off     = req_addr[OW-1:0];
        strb    = NB'(((1 << (1 << size)) - 1) << off);
        rep     = '0;
        for (int i = 0; i < NB; i++)
            rep[i*8 +: 8] = req_wdata[(i & ((1 << size) - 1))*8 +: 8];
    end

    // Load extraction: move the selected bytes to the top, then shift back down with or without sign fill
    always_comb begin
        rd_off = data_addr_q[OW-1:0];
        lsh    = DATA_W - (8 << data_size_q);
        sh     = (data_rdata >> {rd_off, 3'b000}) << lsh;
        sx     = $signed(sh) >>> lsh;
        ext    = (op_q inside {4'd1, 4'd3, 4'd8}) ? sh >> lsh : sx;
    end

    always_comb begin
        state_d        = state_q;
        op_d           = op_q;
        discard_d      = discard_q;
        data_req_d     = data_req_q;
        data_wr_d      = data_wr_q;
        data_size_d    = data_size_q;
        data_addr_d    = data_addr_q;
        data_wstrb_d   = data_wstrb_q;
        data_wdata_d   = data_wdata_q;
        rsp_valid_d    = rsp_valid_q;
        rsp_rdata_d    = rsp_rdata_q;
        rsp_exc_d      = rsp_exc_q;
        rsp_badvaddr_d = rsp_badvaddr_q;
        case (state_q)
            IDLE: if (req_valid && !flush) begin
                op_d           = req_op;
                rsp_rdata_d    = '0;
                rsp_exc_d      = !legal ? 2'd3 : !aligned ? (store ? 2'd2 : 2'd1) : 2'd0;
                rsp_badvaddr_d = (legal && aligned) ? '0 : req_addr;
                if (!legal || !aligned) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                end else begin
                    state_d      = REQ;
                    data_req_d   = 1'b1;
                    data_wr_d    = store;
                    data_size_d  = size;
                    data_addr_d  = req_addr;
                    data_wstrb_d = store ? strb : '0;
                    data_wdata_d = store ? rep : '0;
                end
            end
            REQ: if (data_addr_ok) begin
                state_d    = WAIT;
                data_req_d = 1'b0;
                discard_d  = flush;
            end else if (flush) begin
                state_d    = IDLE;
                data_req_d = 1'b0;
            end
            WAIT: if (data_data_ok) begin
                discard_d = 1'b0;
                if (discard_q || flush) begin
                    state_d = IDLE;
                end else begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = data_wr_q ? '0 : ext;
                end
            end else if (flush) begin
                discard_d = 1'b1;
            end
            RESP: if (flush || rsp_ready) begin
                state_d     = IDLE;
                rsp_valid_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q        <= IDLE;
            op_q           <= '0;
            discard_q      <= 1'b0;
            data_req_q     <= 1'b0;
            data_wr_q      <= 1'b0;
            data_size_q    <= '0;
            data_addr_q    <= '0;
            data_wstrb_q   <= '0;
            data_wdata_q   <= '0;
            rsp_valid_q    <= 1'b0;
            rsp_rdata_q    <= '0;
            rsp_exc_q      <= '0;
            rsp_badvaddr_q <= '0;
        end else begin
            state_q        <= state_d;
            op_q           <= op_d;
            discard_q      <= discard_d;
            data_req_q     <= data_req_d;
            data_wr_q      <= data_wr_d;
            data_size_q    <= data_size_d;
            data_addr_q    <= data_addr_d;
            data_wstrb_q   <= data_wstrb_d;
            data_wdata_q   <= data_wdata_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_rdata_q    <= rsp_rdata_d;
            rsp_exc_q      <= rsp_exc_d;
            rsp_badvaddr_q <= rsp_badvaddr_d;
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: drives a 32-bit and a 64-bit instance through directed and random
// load/store/flush scenarios and compares every cycle against a byte-level reference model.
module tb_mem_access_unit;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetn, sel64, req_valid, flush, data_addr_ok, data_data_ok, rsp_ready;
    logic [3:0]  req_op;
    logic [31:0] req_addr;
    logic [63:0] req_wdata, data_rdata;
    int          n_cmp = 0, n_err = 0;

    logic        s_ready, s_dreq, s_wr, s_valid;
    logic [1:0]  s_size, s_exc;
    logic [31:0] s_addr, s_bad, s_wdata, s_rdata;
    logic [3:0]  s_strb;
    logic        w_ready, w_dreq, w_wr, w_valid;
    logic [1:0]  w_size, w_exc;
    logic [31:0] w_addr, w_bad;
    logic [63:0] w_wdata, w_rdata;
    logic [7:0]  w_strb;

    logic        o_ready, o_dreq, o_wr, o_valid;
    logic [1:0]  o_size, o_exc;
    logic [31:0] o_addr, o_bad;
    logic [7:0]  o_strb;
    logic [63:0] o_wdata, o_rdata;

    assign o_ready = sel64 ? w_ready : s_ready;
    assign o_dreq  = sel64 ? w_dreq  : s_dreq;
    assign o_wr    = sel64 ? w_wr    : s_wr;
    assign o_valid = sel64 ? w_valid : s_valid;
    assign o_size  = sel64 ? w_size  : s_size;
    assign o_exc   = sel64 ? w_exc   : s_exc;
    assign o_addr  = sel64 ? w_addr  : s_addr;
    assign o_bad   = sel64 ? w_bad   : s_bad;
    assign o_strb  = sel64 ? w_strb  : {4'b0, s_strb};
    assign o_wdata = sel64 ? w_wdata : {32'b0, s_wdata};
    assign o_rdata = sel64 ? w_rdata : {32'b0, s_rdata};

    mem_access_unit #(.DATA_W(32), .ADDR_W(32)) u32 (
        .clk(clk), .resetn(resetn), .req_valid(req_valid && !sel64), .req_ready(s_ready),
        .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata[31:0]), .flush(flush),
        .data_req(s_dreq), .data_wr(s_wr), .data_size(s_size), .data_addr(s_addr),
        .data_wstrb(s_strb), .data_wdata(s_wdata), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok), .data_rdata(data_rdata[31:0]), .rsp_valid(s_valid),
        .rsp_ready(rsp_ready), .rsp_rdata(s_rdata), .rsp_exc(s_exc), .rsp_badvaddr(s_bad)
    );

    mem_access_unit #(.DATA_W(64), .ADDR_W(32)) u64 (
        .clk(clk), .resetn(resetn), .req_valid(req_valid && sel64), .req_ready(w_ready),
        .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata), .flush(flush),
        .data_req(w_dreq), .data_wr(w_wr), .data_size(w_size), .data_addr(w_addr),
        .data_wstrb(w_strb), .data_wdata(w_wdata), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok), .data_rdata(data_rdata), .rsp_valid(w_valid),
        .rsp_ready(rsp_ready), .rsp_rdata(w_rdata), .rsp_exc(w_exc), .rsp_badvaddr(w_bad)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: walk byte lanes explicitly from the op's access width
    function automatic void model(input logic s, input logic [3:0] op, input logic [31:0] a,
                                  input logic [63:0] wd, input logic [63:0] rd,
                                  output logic [1:0] exc, output logic [1:0] sz, output logic st,
                                  output logic [7:0] strb, output logic [63:0] bwd,
                                  output logic [63:0] res);
        int lanes, n, off;
        logic sgn;
        logic [63:0] v;
        lanes = s ? 8 : 4;
        st    = op inside {4'd5, 4'd6, 4'd7, 4'd10};
        sgn   = op inside {4'd0, 4'd2, 4'd4, 4'd9};
        n     = (op inside {4'd0, 4'd1, 4'd5}) ? 1 : (op inside {4'd2, 4'd3, 4'd6}) ? 2 :
                (op inside {4'd9, 4'd10}) ? 8 : 4;
        sz    = (n == 1) ? 2'd0 : (n == 2) ? 2'd1 : (n == 4) ? 2'd2 : 2'd3;
        exc   = (op > 4'd10 || (!s && op > 4'd7)) ? 2'd3 : (a % n != 0) ? (st ? 2'd2 : 2'd1) : 2'd0;
        off   = int'(a % lanes);
        strb  = '0;
        bwd   = '0;
        res   = '0;
        if (exc == 2'd0 && st)
            for (int l = 0; l < lanes; l++) begin
                strb[l] = (l >= off && l < off + n);
                bwd[l*8 +: 8] = wd[(l % n)*8 +: 8];
            end
        if (exc == 2'd0 && !st) begin
            v = '0;
            for (int k = 0; k < n; k++) v[k*8 +: 8] = rd[(off + k)*8 +: 8];
            if (sgn && n < 8 && v[n*8-1])
                for (int k = n; k < 8; k++) v[k*8 +: 8] = 8'hFF;
            res = s ? v : {32'b0, v[31:0]};
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input logic s, input logic [3:0] op, input logic [31:0] addr,
                         input logic [63:0] wd, input logic [63:0] rd,
                         input int alat, input int dlat, input int hold);
        logic [1:0] exc, sz;
        logic st;
        logic [7:0] strb;
        logic [63:0] bwd, res;
        model(s, op, addr, wd, rd, exc, sz, st, strb, bwd, res);
        sel64 = s; req_op = op; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
        #1;
        chk("accept_ready", o_ready, 1);
        tick();
        req_valid = 1'b0;
        if (exc != 2'd0) begin
            chk("exc_no_dreq", o_dreq, 0);
            chk("exc_valid", o_valid, 1);
            chk("exc_code", o_exc, exc);
            chk("exc_badvaddr", o_bad, addr);
        end else begin
            chk("bus_dreq", o_dreq, 1);
            chk("bus_wr", o_wr, st);
            chk("bus_size", o_size, sz);
            chk("bus_addr", o_addr, addr);
            chk("bus_wstrb", o_strb, strb);
            chk("bus_wdata", o_wdata, bwd);
            chk("busy_ready", o_ready, 0);
            repeat (alat) begin
                data_data_ok = 1'($urandom % 2);
                tick();
                chk("req_hold", o_dreq, 1);
            end
            data_data_ok = 1'b0;
            data_addr_ok = 1'b1;
            tick();
            data_addr_ok = 1'b0;
            chk("req_drop", o_dreq, 0);
            repeat (dlat) begin
                data_rdata = {$urandom, $urandom};
                tick();
                chk("wait_no_rsp", o_valid, 0);
            end
            data_rdata = rd;
            data_data_ok = 1'b1;
            tick();
            data_data_ok = 1'b0;
            data_rdata = {$urandom, $urandom};
            chk("rsp_valid", o_valid, 1);
            chk("rsp_exc", o_exc, 0);
        end
        chk("rsp_rdata", o_rdata, res);
        chk("resp_ready", o_ready, 0);
        repeat (hold) begin
            req_valid = 1'b1;
            req_op = 4'($urandom_range(0, 12));
            tick();
            chk("hold_valid", o_valid, 1);
            chk("hold_rdata", o_rdata, res);
            chk("hold_ready", o_ready, 0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("done_ready", o_ready, 1);
        chk("done_valid", o_valid, 0);
        chk("done_dreq", o_dreq, 0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"}, o_ready, 1);
        chk({tag, "_dreq"}, o_dreq, 0);
        chk({tag, "_wr"}, o_wr, 0);
        chk({tag, "_size"}, o_size, 0);
        chk({tag, "_addr"}, o_addr, 0);
        chk({tag, "_wstrb"}, o_strb, 0);
        chk({tag, "_wdata"}, o_wdata, 0);
        chk({tag, "_valid"}, o_valid, 0);
        chk({tag, "_rdata"}, o_rdata, 0);
        chk({tag, "_exc"}, o_exc, 0);
        chk({tag, "_bad"}, o_bad, 0);
    endtask

    initial begin
        resetn = 1'b0; sel64 = 1'b0; req_valid = 1'b0; flush = 1'b0; rsp_ready = 1'b0;
        data_addr_ok = 1'b0; data_data_ok = 1'b0; req_op = '0; req_addr = '0;
        req_wdata = '0; data_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("rst32");
        sel64 = 1'b1;
        #1;
        chk_reset_outputs("rst64");
        resetn = 1'b1;
        tick();

        do_op(0, 4'd0, 32'h1003, '0, 64'h80FF_1234, 0, 0, 0);
        do_op(0, 4'd6, 32'h2002, 64'h0000_ABCD, '0, 0, 0, 0);
        do_op(0, 4'd4, 32'h6, '0, '0, 0, 0, 0);
        do_op(0, 4'd7, 32'h6, 64'h1234, '0, 0, 0, 0);
        do_op(1, 4'd8, 32'h0C, '0, 64'h9000_0001_0000_0000, 1, 1, 0);
        do_op(1, 4'd10, 32'h10, 64'h0123_4567_89AB_CDEF, '0, 0, 2, 0);
        do_op(0, 4'd9, 32'h10, '0, '0, 0, 0, 1);
        do_op(0, 4'd4, 32'h40, '0, 64'hDEAD_BEEF, 2, 1, 5);

        // flush together with an accept: request dropped
        sel64 = 1'b0; req_op = 4'd4; req_addr = 32'h40; req_valid = 1'b1; flush = 1'b1;
        tick();
        req_valid = 1'b0; flush = 1'b0;
        chk("flush_acc_ready", o_ready, 1);
        chk("flush_acc_dreq", o_dreq, 0);
        // flush in REQ before addr_ok
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        chk("flush_req_up", o_dreq, 1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_req_dreq", o_dreq, 0);
        chk("flush_req_ready", o_ready, 1);
        // flush in WAIT, data_ok four cycles later
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0; data_addr_ok = 1'b1;
        tick();
        data_addr_ok = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0;
        repeat (3) begin
            chk("disc_valid", o_valid, 0);
            chk("disc_ready", o_ready, 0);
            tick();
        end
        data_data_ok = 1'b1; data_rdata = 64'h5555_AAAA;
        chk("disc_valid_ok", o_valid, 0);
        tick();
        data_data_ok = 1'b0;
        chk("disc_done_ready", o_ready, 1);
        chk("disc_done_valid", o_valid, 0);
        // flush coinciding with addr_ok
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0; data_addr_ok = 1'b1; flush = 1'b1;
        tick();
        data_addr_ok = 1'b0; flush = 1'b0;
        chk("flush_aok_dreq", o_dreq, 0);
        chk("flush_aok_ready", o_ready, 0);
        data_data_ok = 1'b1;
        tick();
        data_data_ok = 1'b0;
        chk("flush_aok_idle", o_ready, 1);
        chk("flush_aok_valid", o_valid, 0);
        // flush in RESP drops the response
        req_addr = 32'h6; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        chk("flush_resp_up", o_valid, 1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_resp_valid", o_valid, 0);
        chk("flush_resp_ready", o_ready, 1);
        // asynchronous reset while in REQ
        req_addr = 32'h80; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        chk("mid_rst_dreq", o_dreq, 1);
        resetn = 1'b0;
        #1;
        chk_reset_outputs("mid_rst");
        #1;
        resetn = 1'b1;
        tick();
        chk("post_rst_ready", o_ready, 1);

        for (int t = 0; t < 150; t++) begin
            logic [31:0] a;
            a = $urandom;
            if ($urandom % 2 == 0) a[2:0] = 3'b000;
            do_op(1'($urandom % 2), 4'($urandom_range(0, 12)), a, {$urandom, $urandom},
                  {$urandom, $urandom}, $urandom_range(0, 2), $urandom_range(0, 2),
                  $urandom_range(0, 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
